// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared memory bus between per-core cache controllers.
// Grants one owner at a time, bounds its tenure to MAX_HOLD cycles, and forces an idle gap between owners.
module bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_arb,
    output logic [NUM_REQ-1:0] gnt_arb,
    output logic [ID_W-1:0]    gnt_id,
    output logic               bus_busy,
    output logic               timeout,
    output logic               dbg_state_o
);

    // Handshake: a cache holds req_arb[i] high until it has been served; it may
    // drive or sample the bus only in cycles where gnt_arb[i] is high. Dropping
    // req_arb[i] while granted releases the bus at the next edge.

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int CW     = ID_W + 1;

    localparam logic [CW-1:0]      NUM_REQ_C = CW'(NUM_REQ);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [ID_W-1:0]     id_q;
    logic                busy_q;
    logic                timeout_q;
    logic [ID_W-1:0]     ptr_q;
    logic [HOLD_W-1:0]   hold_q;

    logic                win_valid;
    logic [ID_W-1:0]     win_id;
    logic [CW-1:0]       cand;
    logic [CW-1:0]       ptr_sum;
    logic [ID_W-1:0]     ptr_d;
    logic                owner_req;

    // Scan ptr, ptr+1, ... wrapping mod NUM_REQ; the first set request wins.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!win_valid && req_arb[cand[ID_W-1:0]]) begin
                win_valid = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    // Pointer moves to the slot just after the releasing owner.
    always_comb begin
        ptr_sum = {1'b0, id_q} + CW'(1);
        ptr_d   = ptr_sum[ID_W-1:0];
        if (ptr_sum >= NUM_REQ_C) begin
            ptr_d = '0;
        end
    end

    assign owner_req = req_arb[id_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        gnt_q   <= GNT_ONE << win_id;
                        id_q    <= win_id;
                        busy_q  <= 1'b1;
                        hold_q  <= HOLD_ONE;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!owner_req || (hold_q == HOLD_MAX)) begin
                        // A release with the request still up is a forced revoke.
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr_q     <= ptr_d;
                        timeout_q <= owner_req;
                        state_q   <= S_IDLE;
                    end else begin
                        hold_q <= hold_q + HOLD_ONE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_arb     = gnt_q;
    assign gnt_id      = id_q;
    assign bus_busy    = busy_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = (state_q == S_GRANT);

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
    a_hold_bound : assert property (@(posedge clk) disable iff (!rst) hold_q <= HOLD_MAX);
    a_busy_match : assert property (@(posedge clk) disable iff (!rst) busy_q == (gnt_q != '0));
    a_tmo_idle   : assert property (@(posedge clk) disable iff (!rst) timeout_q |-> (gnt_q == '0));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single grant, round robin, timeout,
// fairness under contention and pointer wrap, with hand-computed expectations.
module tb_bus_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 16;
    localparam int ID_W     = 2;

    logic               clk;
    logic               rst;
    logic [NUM_REQ-1:0] req_arb;
    logic [NUM_REQ-1:0] gnt_arb;
    logic [ID_W-1:0]    gnt_id;
    logic               bus_busy;
    logic               timeout;
    logic               dbg_state;

    int n_cmp;
    int n_err;
    int onehot_err;
    int tmo_cnt;

    // Scoreboard entries are {timeout, gnt_arb}.
    logic [7:0] exp_q[$];

    bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_arb    (req_arb),
        .gnt_arb    (gnt_arb),
        .gnt_id     (gnt_id),
        .bus_busy   (bus_busy),
        .timeout    (timeout),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (rst) begin
            if ((gnt_arb & (gnt_arb - 1'b1)) != '0) onehot_err++;
            if (timeout) tmo_cnt++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {27'd0, timeout, gnt_arb}, {24'd0, e});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        req_arb = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp      = 0;
        n_err      = 0;
        onehot_err = 0;
        tmo_cnt    = 0;
        rst        = 1'b0;
        req_arb    = '0;
        tick();
        tick();

        check("rst_gnt",  32'(gnt_arb),   32'h0);
        check("rst_id",   32'(gnt_id),    32'h0);
        check("rst_busy", 32'(bus_busy),  32'h0);
        check("rst_tmo",  32'(timeout),   32'h0);
        check("rst_st",   32'(dbg_state), 32'h0);
        rst = 1'b1;
        tick();
        check("idle_gnt", 32'(gnt_arb), 32'h0);

        // Single requester.
        req_arb = 4'b0010;
        tick();
        check("single_gnt",  32'(gnt_arb),  32'h2);
        check("single_id",   32'(gnt_id),   32'h1);
        check("single_busy", 32'(bus_busy), 32'h1);
        req_arb = 4'b0000;
        tick();
        check("single_rel",    32'(gnt_arb),  32'h0);
        check("single_relbsy", 32'(bus_busy), 32'h0);
        check("single_holdid", 32'(gnt_id),   32'h1);

        // Reset mid-tenure (ptr is now 2).
        req_arb = 4'b0100;
        tick();
        check("mid_gnt", 32'(gnt_arb), 32'h4);
        #2 rst = 1'b0;
        #1;
        check("async_gnt",  32'(gnt_arb),  32'h0);
        check("async_busy", 32'(bus_busy), 32'h0);
        check("async_id",   32'(gnt_id),   32'h0);
        tick();
        rst     = 1'b1;
        req_arb = 4'b1111;
        tick();
        check("post_rst_gnt", 32'(gnt_arb), 32'h1);
        req_arb = 4'b0000;
        tick();

        // Round robin: 3-cycle tenures, 1-cycle gaps, order 0,1,2,3,0.
        do_reset();
        tmo_cnt = 0;
        req_arb = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            logic [NUM_REQ-1:0] g;
            int o;
            o = (n == 4) ? 0 : n;
            g = 4'(1 << o);
            tick();
            check($sformatf("rr%0d_gnt", n), 32'(gnt_arb), 32'(g));
            check($sformatf("rr%0d_id", n),  32'(gnt_id),  32'(o));
            tick();
            check($sformatf("rr%0d_h2", n), 32'(gnt_arb), 32'(g));
            tick();
            check($sformatf("rr%0d_h3", n), 32'(gnt_arb), 32'(g));
            req_arb[o] = 1'b0;
            tick();
            check($sformatf("rr%0d_gap", n), 32'(gnt_arb), 32'h0);
            req_arb[o] = 1'b1;
        end
        req_arb = 4'b0000;
        tick();
        check("rr_no_tmo", 32'(tmo_cnt), 32'h0);

        // Timeout: sole requester 0 held 40 cycles (ptr is 1, scan wraps to 0).
        for (int t = 0; t < 40; t++) begin
            int ph;
            ph = t % 17;
            exp_q.push_back((ph < 16) ? 8'h01 : 8'h10);
        end
        req_arb = 4'b0001;
        for (int t = 0; t < 40; t++) begin
            tick();
            check_sb($sformatf("tmo_t%0d", t + 1));
        end
        req_arb = 4'b0000;
        tick();
        check("tmo_rel_gnt", 32'(gnt_arb), 32'h0);
        check("tmo_rel_tmo", 32'(timeout), 32'h0);

        // Fairness: 0 and 2 contend; forced releases alternate ownership.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            int ph;
            int k;
            ph = t % 17;
            k  = t / 17;
            if (ph < 16) exp_q.push_back((k % 2 == 0) ? 8'h01 : 8'h04);
            else         exp_q.push_back(8'h10);
        end
        req_arb = 4'b0101;
        for (int t = 0; t < 40; t++) begin
            tick();
            check_sb($sformatf("fair_t%0d", t + 1));
        end
        req_arb = 4'b0000;
        tick();
        check("fair_rel", 32'(gnt_arb), 32'h0);

        // Wrap: owner 2 releases with 3 and 0 waiting -> 3, then 0 (ptr is 1).
        tmo_cnt = 0;
        req_arb = 4'b0100;
        tick();
        check("wrap_g2", 32'(gnt_arb), 32'h4);
        req_arb = 4'b1101;
        tick();
        check("wrap_g2_hold", 32'(gnt_arb), 32'h4);
        req_arb = 4'b1001;
        tick();
        check("wrap_gap1", 32'(gnt_arb), 32'h0);
        tick();
        check("wrap_g3",    32'(gnt_arb), 32'h8);
        check("wrap_g3_id", 32'(gnt_id),  32'h3);
        req_arb = 4'b0001;
        tick();
        check("wrap_gap2", 32'(gnt_arb), 32'h0);
        tick();
        check("wrap_g0",    32'(gnt_arb), 32'h1);
        check("wrap_g0_id", 32'(gnt_id),  32'h0);
        req_arb = 4'b0000;
        tick();
        check("wrap_idle",   32'(gnt_arb), 32'h0);
        check("wrap_no_tmo", 32'(tmo_cnt), 32'h0);
        check("onehot_all",  32'(onehot_err), 32'h0);
        check("sb_drained",  32'(exp_q.size()), 32'h0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
